// File: rtl/usb_pkg.sv
// Shared USB definitions: token/direction encodings, field widths and the OUT receiver states.
package usb_pkg;

  localparam int unsigned EpW  = 4;
  localparam int unsigned CntW = 8;

  localparam logic DirOut = 1'b0;
  localparam logic DirIn  = 1'b1;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StSkip
  } rx_state_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + CntW'(1);
  endfunction

endpackage

// File: rtl/usb_out_buf.sv
// Byte RAM for the OUT receiver: one write port, one read port with registered read data.
module usb_out_buf #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_out_receiver.sv
// OUT-endpoint sink: stages each packet speculatively, commits on success, rolls back on failure,
// and presents committed bytes to a show-ahead consumer.
module usb_out_receiver
  import usb_pkg::*;
#(
  parameter int unsigned EP      = 1,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned MAX_PKT = 8
) (
  input  logic            clk48_i,
  input  logic            rst_ni,
  input  logic            usb_rst_i,
  input  logic            transaction_active_i,
  input  logic [EpW-1:0]  endpoint_i,
  input  logic            direction_in_i,
  input  logic            setup_i,
  input  logic            data_strobe_i,
  input  logic [7:0]      din_i,
  input  logic            success_i,
  output logic            out_ready_o,
  output logic [7:0]      dout_o,
  output logic            dout_v_o,
  input  logic            dout_rdy_i,
  output logic [CntW-1:0] drop_cnt_o
);

  localparam int unsigned Aw = $clog2(DEPTH);
  localparam int unsigned Pw = Aw + 1;
  localparam logic [Pw-1:0] DepthP  = Pw'(DEPTH);
  localparam logic [Pw-1:0] MaxPktP = Pw'(MAX_PKT);
  localparam logic [Pw-1:0] OneP    = Pw'(1);

  rx_state_e       state_q;
  logic            active_q, ovf_q, out_ready_q, dout_v_q;
  logic [Pw-1:0]   wr_ptr_q, wr_tmp_q, rd_ptr_q;
  logic [CntW-1:0] drop_cnt_q;

  logic            start, stop, pop, room, we, commit;
  logic [Pw-1:0]   wr_ptr_d, rd_ptr_d, used, free;

  always_comb begin
    start    = transaction_active_i & ~active_q;
    stop     = ~transaction_active_i & active_q;
    pop      = dout_v_q & dout_rdy_i;
    room     = (wr_tmp_q - wr_ptr_q) != MaxPktP;
    we       = (state_q == StRecv) & data_strobe_i & room;
    commit   = (state_q == StRecv) & stop & success_i & ~ovf_q;
    wr_ptr_d = commit ? wr_tmp_q : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + OneP : rd_ptr_q;
    used     = wr_ptr_q - rd_ptr_q;
    free     = DepthP - used;
  end

  always_ff @(posedge clk48_i) begin
    if (!rst_ni || usb_rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      wr_tmp_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      out_ready_q <= 1'b1;
      dout_v_q    <= 1'b0;
      // A bus reset keeps tracking the line so a still-high strobe is not seen as a new start
      active_q    <= rst_ni ? transaction_active_i : 1'b0;
      if (!rst_ni) begin
        drop_cnt_q <= '0;
      end
    end else begin
      active_q    <= transaction_active_i;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_ready_q <= free >= MaxPktP;
      dout_v_q    <= rd_ptr_d != wr_ptr_d;
      if (we) begin
        wr_tmp_q <= wr_tmp_q + OneP;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (endpoint_i == EpW'(EP) && direction_in_i == DirOut && !setup_i && out_ready_q) begin
              state_q  <= StRecv;
              wr_tmp_q <= wr_ptr_q;
              ovf_q    <= 1'b0;
            end else begin
              state_q <= StSkip;
            end
          end
        end
        StRecv: begin
          if (data_strobe_i && !room) begin
            ovf_q <= 1'b1;
          end
          if (stop) begin
            state_q <= StIdle;
            if (!commit) begin
              wr_tmp_q   <= wr_ptr_q;
              drop_cnt_q <= sat_inc(drop_cnt_q);
            end
          end
        end
        StSkip: begin
          if (stop) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  usb_out_buf #(
    .Depth (DEPTH),
    .Aw    (Aw)
  ) u_buf (
    .clk_i   (clk48_i),
    .rst_ni  (rst_ni),
    .clr_i   (usb_rst_i),
    .we_i    (we),
    .waddr_i (wr_tmp_q[Aw-1:0]),
    .wdata_i (din_i),
    .raddr_i (rd_ptr_d[Aw-1:0]),
    .rdata_o (dout_o)
  );

  assign out_ready_o = out_ready_q;
  assign dout_v_o    = dout_v_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_usb_out_receiver.sv
// Directed and randomized bench for usb_out_receiver against a packet-level queue model.
module tb_usb_out_receiver;

  localparam int unsigned EP      = 1;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned MAX_PKT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       usb_rst = 1'b0;
  logic       transaction_active = 1'b0;
  logic [3:0] endpoint = '0;
  logic       direction_in = 1'b0;
  logic       setup = 1'b0;
  logic       data_strobe = 1'b0;
  logic [7:0] din = '0;
  logic       success = 1'b0;
  logic       out_ready;
  logic [7:0] dout;
  logic       dout_v;
  logic       dout_rdy = 1'b0;
  logic [7:0] drop_cnt;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] mq[$];
  int         mdrop = 0;
  logic [7:0] pk[16];

  usb_out_receiver #(
    .EP      (EP),
    .DEPTH   (DEPTH),
    .MAX_PKT (MAX_PKT)
  ) dut (
    .clk48_i              (clk),
    .rst_ni               (rst_n),
    .usb_rst_i            (usb_rst),
    .transaction_active_i (transaction_active),
    .endpoint_i           (endpoint),
    .direction_in_i       (direction_in),
    .setup_i              (setup),
    .data_strobe_i        (data_strobe),
    .din_i                (din),
    .success_i            (success),
    .out_ready_o          (out_ready),
    .dout_o               (dout),
    .dout_v_o             (dout_v),
    .dout_rdy_i           (dout_rdy),
    .drop_cnt_o           (drop_cnt)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packet-level reference: accepted only if matching and at least MAX_PKT bytes free.
  task automatic model_pkt(input int ep, input bit dir, input bit stp, input int n, input bit succ);
    if (ep == int'(EP) && !dir && !stp && (int'(DEPTH) - mq.size()) >= int'(MAX_PKT)) begin
      if (succ && n <= int'(MAX_PKT)) begin
        for (int i = 0; i < n; i++) mq.push_back(pk[i]);
      end else if (mdrop < 255) begin
        mdrop++;
      end
    end
  endtask

  task automatic send_pkt(input int ep, input bit dir, input bit stp, input int n, input bit succ);
    model_pkt(ep, dir, stp, n, succ);
    endpoint = 4'(ep);
    direction_in = dir;
    setup = stp;
    transaction_active = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      din = pk[i];
      data_strobe = 1'b1;
      tick();
      data_strobe = 1'b0;
      if (i[0]) tick();
    end
    transaction_active = 1'b0;
    success = succ;
    tick();
    success = 1'b0;
    repeat (2) tick();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".dout_v"}, 32'(dout_v), 32'(mq.size() != 0));
    chk({tag, ".out_ready"}, 32'(out_ready), 32'((int'(DEPTH) - mq.size()) >= int'(MAX_PKT)));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(mdrop));
  endtask

  task automatic drain(input string tag);
    dout_rdy = 1'b1;
    while (mq.size() != 0) begin
      chk({tag, ".v"}, 32'(dout_v), 32'd1);
      chk({tag, ".data"}, 32'(dout), 32'(mq[0]));
      void'(mq.pop_front());
      tick();
    end
    chk({tag, ".empty"}, 32'(dout_v), 32'd0);
    dout_rdy = 1'b0;
    tick();
    chk({tag, ".ready"}, 32'(out_ready), 32'd1);
  endtask

  task automatic partial_then_reset(input bit bus);
    endpoint = 4'(EP);
    direction_in = 1'b0;
    setup = 1'b0;
    transaction_active = 1'b1;
    tick();
    repeat (3) begin
      din = 8'($urandom);
      data_strobe = 1'b1;
      tick();
      data_strobe = 1'b0;
    end
    if (bus) usb_rst = 1'b1;
    else rst_n = 1'b0;
    transaction_active = 1'b0;
    tick();
    usb_rst = 1'b0;
    rst_n = 1'b1;
    mq.delete();
    if (!bus) mdrop = 0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst.out_ready", 32'(out_ready), 32'd1);
    chk("rst.dout_v", 32'(dout_v), 32'd0);
    chk("rst.dout", 32'(dout), 32'd0);
    chk("rst.drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single good packet
    pk[0] = 8'h41; pk[1] = 8'h42; pk[2] = 8'h43;
    send_pkt(EP, 1'b0, 1'b0, 3, 1'b1);
    chk_state("good3");
    drain("good3");

    // Failed packet then a good two-byte packet
    for (int i = 0; i < 5; i++) pk[i] = 8'hA0 + 8'(i);
    send_pkt(EP, 1'b0, 1'b0, 5, 1'b0);
    chk_state("bad5");
    pk[0] = 8'h11; pk[1] = 8'h22;
    send_pkt(EP, 1'b0, 1'b0, 2, 1'b1);
    chk_state("good2");
    drain("good2");

    // Non-matching transactions
    for (int i = 0; i < 3; i++) pk[i] = 8'h55 + 8'(i);
    send_pkt(EP, 1'b1, 1'b0, 3, 1'b1);
    chk_state("in");
    send_pkt(EP, 1'b0, 1'b1, 3, 1'b1);
    chk_state("setup");
    send_pkt(2, 1'b0, 1'b0, 3, 1'b1);
    chk_state("ep2");

    // Fill to capacity with the consumer stalled
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 8; i++) pk[i] = 8'(p * 8 + i);
      send_pkt(EP, 1'b0, 1'b0, 8, 1'b1);
      chk_state($sformatf("fill%0d", p));
    end
    drain("fill");

    // Oversize packet
    for (int i = 0; i < 9; i++) pk[i] = 8'hC0 + 8'(i);
    send_pkt(EP, 1'b0, 1'b0, 9, 1'b1);
    chk_state("ovf9");

    // Bus reset and then hard reset, each mid-packet with committed bytes pending
    for (int i = 0; i < 4; i++) pk[i] = 8'h60 + 8'(i);
    send_pkt(EP, 1'b0, 1'b0, 4, 1'b1);
    partial_then_reset(1'b1);
    chk_state("usb_rst");
    repeat (2) tick();
    send_pkt(EP, 1'b0, 1'b0, 4, 1'b1);
    send_pkt(EP, 1'b0, 1'b0, 2, 1'b0);
    partial_then_reset(1'b0);
    chk_state("rst");
    chk("rst.dout2", 32'(dout), 32'd0);
    repeat (2) tick();

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int  ep, n;
      bit  dir, stp, succ;
      ep   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'(EP);
      dir  = ($urandom_range(0, 5) == 0);
      stp  = ($urandom_range(0, 5) == 0);
      n    = int'($urandom_range(0, 9));
      succ = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < n; i++) pk[i] = 8'($urandom);
      send_pkt(ep, dir, stp, n, succ);
      chk_state($sformatf("rnd%0d", it));
      if ($urandom_range(0, 2) == 0) drain($sformatf("rnd%0d", it));
    end
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
